// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the controller state encoding, the funct3 access encodings for
// loads and stores, and the byte-lane count of a memory word.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/lsu_ram.sv
// Single-port synchronous data RAM for the load/store unit.
// Ports:
//   clk_i   - clock, all activity on the rising edge
//   en_i    - port enable; read data only updates when enabled
//   we_i    - per-byte write enables, lane 0 is bits [7:0]
//   idx_i   - word index
//   wdata_i - write data, already placed on the correct lanes
//   rdata_o - registered read data (old contents on a write cycle)
module lsu_ram
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                      clk_i,
  input  logic                      en_i,
  input  logic [BYTES_PER_WORD-1:0] we_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [31:0]               wdata_i,
  output logic [31:0]               rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Memory has no reset so stored contents survive a controller reset.
  // Read data holds its value while the port is idle, which keeps the
  // unit's load result stable for as long as a response is stalled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (we_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with a private word-addressed data memory.
// A request is accepted in IDLE, the RAM is accessed for one cycle in
// ACCESS, and the result is held in RESP until the consumer takes it.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   req_valid/req_ready   - request handshake
//   mem_read/mem_write    - operation select
//   funct3                - access size and signedness
//   addr, wdata           - byte address and store data
//   resp_valid/resp_ready - response handshake
//   rdata, err            - load result and fault flag
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  lsu_state_e       state_q;
  logic             reqReady_q;
  logic             respValid_q;
  logic             err_q;
  logic             isStore_q;
  logic [2:0]       funct3_q;
  logic [IDX_W-1:0] wordIdx_q;
  logic [1:0]       lane_q;
  logic [31:0]      wdata_q;

  logic             err_d;
  logic             funct3Ok;
  logic             misaligned;
  logic             outOfRange;
  logic             accept;

  logic             ramEn;
  logic [3:0]       ramWe;
  logic [31:0]      ramWdata;
  logic [31:0]      ramRdata;
  logic [7:0]       loadByte;
  logic [15:0]      loadHalf;

  assign accept = req_valid && reqReady_q && (mem_read || mem_write);

  // Fault classification of the incoming request. The unsigned load
  // encodings are legal only for a pure load; everything else outside
  // b/h/w is rejected. Bits above the word index are caught by the
  // range compare rather than silently aliasing into the RAM.
  always_comb begin
    funct3Ok = 1'b0;
    case (funct3)
      LB, LH, LW: funct3Ok = 1'b1;
      LBU, LHU:   funct3Ok = !mem_write;
      default:    funct3Ok = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    outOfRange = {2'b00, addr[31:2]} >= DEPTH_LIMIT;
    err_d      = (mem_read && mem_write) || !funct3Ok || misaligned || outOfRange;
  end

  // Controller. Only the request fields needed later are captured at the
  // accept edge, so the request inputs are free to change afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      reqReady_q  <= 1'b0;
      respValid_q <= 1'b0;
      err_q       <= 1'b0;
      isStore_q   <= 1'b0;
      funct3_q    <= 3'b000;
      wordIdx_q   <= '0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (accept) begin
            state_q    <= ACCESS;
            reqReady_q <= 1'b0;
            err_q      <= err_d;
            isStore_q  <= mem_write;
            funct3_q   <= funct3;
            wordIdx_q  <= addr[IDX_W+1:2];
            lane_q     <= addr[1:0];
            wdata_q    <= wdata;
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          respValid_q <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state_q     <= IDLE;
            respValid_q <= 1'b0;
            reqReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          respValid_q <= 1'b0;
          reqReady_q  <= 1'b0;
        end
      endcase
    end
  end

  // RAM drive during ACCESS. Store data is replicated across lanes so the
  // byte enables alone pick where it lands. Reset blocks the port so an
  // access interrupted by reset leaves memory untouched.
  always_comb begin
    ramEn    = (state_q == ACCESS) && !reset;
    ramWe    = 4'b0000;
    ramWdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        ramWe    = 4'b0001 << lane_q;
        ramWdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ramWe    = lane_q[1] ? 4'b1100 : 4'b0011;
        ramWdata = {2{wdata_q[15:0]}};
      end
      default: begin
        ramWe    = 4'b1111;
        ramWdata = wdata_q;
      end
    endcase
    if (!(ramEn && isStore_q && !err_q)) begin
      ramWe = 4'b0000;
    end
  end

  lsu_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (ramEn),
    .we_i   (ramWe),
    .idx_i  (wordIdx_q),
    .wdata_i(ramWdata),
    .rdata_o(ramRdata)
  );

  // Load lane selection and extension. Stores and faulted requests
  // return zero.
  always_comb begin
    loadByte = ramRdata[{lane_q, 3'b000} +: 8];
    loadHalf = lane_q[1] ? ramRdata[31:16] : ramRdata[15:0];
    rdata    = 32'h0;
    if (respValid_q && !err_q && !isStore_q) begin
      case (funct3_q)
        LB:      rdata = {{24{loadByte[7]}}, loadByte};
        LH:      rdata = {{16{loadHalf[15]}}, loadHalf};
        LW:      rdata = ramRdata;
        LBU:     rdata = {24'h0, loadByte};
        LHU:     rdata = {16'h0, loadHalf};
        default: rdata = 32'h0;
      endcase
    end
  end

  assign req_ready  = reqReady_q;
  assign resp_valid = respValid_q;
  assign err        = respValid_q && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int fails  = 0;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .rdata     (rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Issues one request and collects its response. lat counts cycles from
  // the accept edge (inclusive) to the first cycle with resp_valid, or 99
  // when the unit never accepts or never responds. Request inputs are
  // scrambled right after the accept edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] gotData, output logic gotErr,
                               output int lat, output logic readyInAccess);
    int guard;
    gotData = 32'h0;
    gotErr = 1'b0;
    lat = 99;
    readyInAccess = 1'b1;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'hFFFF_FFFF; wdata = ~wd; funct3 = 3'b111;
    readyInAccess = req_ready;
    guard = 1;
    while (!resp_valid && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    if (resp_valid) begin
      lat = guard; gotData = rdata; gotErr = err;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_access();
    logic [31:0] d; logic e; int lat; logic rA;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat, rA);
    checks++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL sw_err: got %b expected 0", e); end
    checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL sw_rdata: got %h expected 00000000", d); end
    checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", d); end
    checks++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL lw_err: got %b expected 0", e); end
    checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rA !== 1'b0) begin fails++; $display("[TB] FAIL ready_in_access: got %b expected 0", rA); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic e; int lat; logic rA;
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5, d, e, lat, rA);
    checks++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL sb_err: got %b expected 0", e); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'hDEADA5EF) begin fails++; $display("[TB] FAIL sb_readback: got %h expected deada5ef", d); end
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'hFFFFFFA5) begin fails++; $display("[TB] FAIL lb_11: got %h expected ffffffa5", d); end
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h000000A5) begin fails++; $display("[TB] FAIL lbu_11: got %h expected 000000a5", d); end
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h12, 32'hCCCC1234, d, e, lat, rA);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h1234A5EF) begin fails++; $display("[TB] FAIL sh_readback: got %h expected 1234a5ef", d); end
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h00001234) begin fails++; $display("[TB] FAIL lh_12: got %h expected 00001234", d); end
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'hFFFFA5EF) begin fails++; $display("[TB] FAIL lh_10: got %h expected ffffa5ef", d); end
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h0000A5EF) begin fails++; $display("[TB] FAIL lhu_10: got %h expected 0000a5ef", d); end
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'hFFFFFFEF) begin fails++; $display("[TB] FAIL lb_10: got %h expected ffffffef", d); end
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h00000012) begin fails++; $display("[TB] FAIL lbu_13: got %h expected 00000012", d); end
  endtask

  task automatic test_faults();
    logic [31:0] d; logic e; int lat; logic rA;
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL lh_misaligned_err: got %b expected 1", e); end
    checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL lh_misaligned_rdata: got %h expected 00000000", d); end
    checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL fault_latency: got %0d expected 2", lat); end
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, d, e, lat, rA);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'(4 * DEPTH), 32'h11111111, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL sw_range_err: got %b expected 1", e); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL range_no_write: got %h expected cafef00d", d); end
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h12, 32'h99999999, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL sw_misaligned_err: got %b expected 1", e); end
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h10, 32'h77777777, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL store_bad_funct3_err: got %b expected 1", e); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h1234A5EF) begin fails++; $display("[TB] FAIL faulted_store_no_write: got %h expected 1234a5ef", d); end
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL load_bad_funct3_err: got %b expected 1", e); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL lw_misaligned_err: got %b expected 1", e); end
  endtask

  task automatic test_bad_op();
    logic [31:0] d; logic e; int lat; logic rA;
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL both_ops_err: got %b expected 1", e); end
    checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL both_ops_rdata: got %h expected 00000000", d); end
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL no_op_ready: got %b expected 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL no_op_resp_valid: got %b expected 0", resp_valid); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_stall();
    int guard;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; addr = 32'h0;
    guard = 0;
    while (!resp_valid && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_resp_valid: got %b expected 1", resp_valid); end
      checks++; if (rdata !== 32'h1234A5EF) begin fails++; $display("[TB] FAIL stall_rdata: got %h expected 1234a5ef", rdata); end
      checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_req_ready: got %b expected 0", req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release_valid: got %b expected 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] d; logic e; int lat; logic rA;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'h01020304, d, e, lat, rA);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
    addr = 32'h20; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_write = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_access_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_access_req_ready: got %b expected 0", req_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_release_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_release_resp_valid: got %b expected 0", resp_valid); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h01020304) begin fails++; $display("[TB] FAIL abandoned_store: got %h expected 01020304", d); end
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, rA);
    checks++; if (d !== 32'h1234A5EF) begin fails++; $display("[TB] FAIL mem_kept_over_reset: got %h expected 1234a5ef", d); end
  endtask

  initial begin
    test_reset();
    test_word_access();
    test_byte_lanes();
    test_faults();
    test_bad_op();
    test_stall();
    test_reset_in_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the internal data memory size in 32-bit words (power of two).
REQ-002 Ports SHALL be:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- mem_read  input  1  request is a load
- mem_write  input  1  request is a store
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  input  32  byte address, taken from ALU_result
- wdata  input  32  store data, taken from rs2
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- rdata  output  32  load result, extended to 32 bits
- err  output  1  request faulted
REQ-003 The single clock SHALL be clk; reset SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-005 In IDLE, req_ready SHALL be 1; in ACCESS and RESP it SHALL be 0.
REQ-006 A request SHALL be accepted at a rising edge with req_valid=1, req_ready=1 and mem_read|mem_write=1; the FSM then goes IDLE->ACCESS and latches addr, wdata, funct3 and the op.
REQ-007 A request with req_valid=1 and mem_read=mem_write=0 SHALL be ignored: FSM stays in IDLE and issues no response.
REQ-008 ACCESS SHALL last exactly one cycle, perform the RAM read or byte-enabled write, then go to RESP.
REQ-009 In RESP, resp_valid SHALL be 1 and rdata/err SHALL stay stable until the edge with resp_ready=1, which returns the FSM to IDLE.
REQ-010 Minimum latency SHALL be an accept edge N with resp_valid=1 in the cycle after edge N+1; peak throughput SHALL be one access per 3 cycles.
REQ-011 err SHALL be 1 for any of these cases:
- both mem_read and mem_write set
- funct3 not listed for the op (stores allow only 000/001/010)
- halfword access with addr[0]=1
- word access with addr[1:0]!=0
- addr[31:2] >= DEPTH_WORDS
REQ-012 An errored request SHALL NOT modify memory, SHALL return rdata=0, and SHALL still pass through ACCESS and RESP.
REQ-013 Byte order SHALL be little-endian; word index SHALL be addr[31:2] and byte lane addr[1:0].
REQ-014 Stores SHALL write only the addressed lanes:
- sb: wdata[7:0] to lane addr[1:0]
- sh: wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1
- sw: all four lanes
REQ-015 Loads SHALL select the addressed byte/halfword, sign-extend for lb/lh, zero-extend for lbu/lhu, and return the full word for lw.
REQ-016 A store's response SHALL have rdata=0 and err per REQ-011.
REQ-017 Inputs other than resp_ready SHALL be don't-care outside the accepting cycle.

Reset
REQ-018 While reset=1, the FSM SHALL enter IDLE and outputs SHALL be req_ready=0, resp_valid=0, rdata=0 and err=0.
REQ-019 Reset asserted in ACCESS or RESP SHALL abandon the access with no response; memory contents SHALL NOT be cleared.
REQ-020 req_ready SHALL become 1 in the first cycle after reset deasserts.

Structure
REQ-021 Package lsu_pkg SHALL hold the FSM state enum and the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-022 Sub-module lsu_ram SHALL implement the single-port synchronous RAM with 4 byte-write enables and one-cycle read latency; load_store_unit SHALL contain the FSM, checking and lane logic.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
- sw addr=0x10, wdata=0xDEADBEEF, then lw 0x10 -> rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after accept.
- sb addr=0x11, wdata=0x000000A5 over word 0xDEADBEEF, then lw 0x10 -> 0xDEADA5EF; lb 0x11 -> 0xFFFFFFA5; lbu 0x11 -> 0x000000A5.
- lh addr=0x13 -> err=1, rdata=0; sw addr=4*DEPTH_WORDS -> err=1 and memory unchanged on readback.
- mem_read=mem_write=1 -> err=1; both 0 with req_valid=1 -> req_ready stays 1 and no response.
- resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready=0; reset asserted in ACCESS -> next cycle resp_valid=0 and IDLE with req_ready=1 after deassert.
